// File: rtl/start_sequencer.sv
// start_sequencer
//   Issues one-hot start pulses to N_STAGES downstream FSMs in strict order,
//   advancing to the next stage only after the current one reports done.
//   Restartable via go from IDLE/FINISHED/ERROR; optional per-stage timeout.
// Ports
//   clk       : system clock, rising edge
//   rst       : asynchronous active-high reset
//   go        : launch/relaunch request (ignored while busy)
//   done      : per-stage completion, only done[stage] is observed
//   start     : one-hot start pulse to the current stage
//   busy      : high in DELAY/PULSE/WAIT
//   all_done  : high in FINISHED
//   error     : high in ERROR
//   err_stage : index of the stage that timed out
//
// state    | meaning
// ---------+-------------------------------------------------
// IDLE     | after reset, waiting for auto launch or go
// DELAY    | holding DELAY cycles before the first pulse
// PULSE    | start[stage] high for PULSE_W cycles
// WAIT     | waiting for done[stage], timeout counter running
// FINISHED | all stages done, all_done high
// ERROR    | a stage timed out, err_stage holds its index
module start_sequencer #(
  parameter int N_STAGES   = 3,
  parameter int DELAY      = 0,
  parameter int PULSE_W    = 1,
  parameter int TIMEOUT    = 0,
  parameter int AUTO_START = 1,
  localparam int SW        = (N_STAGES > 1) ? $clog2(N_STAGES) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                go,
  input  logic [N_STAGES-1:0] done,
  output logic [N_STAGES-1:0] start,
  output logic                busy,
  output logic                all_done,
  output logic                error,
  output logic [SW-1:0]       err_stage
);

  localparam int MAX_DP = (DELAY > PULSE_W) ? DELAY : PULSE_W;
  localparam int MAXC   = (MAX_DP > TIMEOUT) ? MAX_DP : TIMEOUT;
  localparam int CW     = ($clog2(MAXC + 1) < 1) ? 1 : $clog2(MAXC + 1);

  localparam logic [CW-1:0] DLY_LAST   = CW'((DELAY > 0) ? DELAY - 1 : 0);
  localparam logic [CW-1:0] PW_LAST    = CW'(PULSE_W - 1);
  localparam logic [CW-1:0] TO_LAST    = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [SW-1:0] LAST_STAGE = SW'(N_STAGES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_DELAY, S_PULSE, S_WAIT, S_FINISHED, S_ERROR
  } state_t;

  state_t        state, state_n;
  logic [SW-1:0] stage, stage_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          done_lat, done_lat_n;
  logic          first, first_n;
  logic [SW-1:0] err_stage_q, err_stage_n;
  logic          launch;
  logic          done_cur;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      stage       <= '0;
      cnt         <= '0;
      done_lat    <= 1'b0;
      first       <= 1'b1;
      err_stage_q <= '0;
    end else begin
      state       <= state_n;
      stage       <= stage_n;
      cnt         <= cnt_n;
      done_lat    <= done_lat_n;
      first       <= first_n;
      err_stage_q <= err_stage_n;
    end
  end

  always_comb begin
    state_n     = state;
    stage_n     = stage;
    cnt_n       = cnt;
    done_lat_n  = done_lat;
    first_n     = first;
    err_stage_n = err_stage_q;
    done_cur    = done[stage];
    launch      = 1'b0;

    case (state)
      S_IDLE:     launch = ((AUTO_START != 0) && first) || go;
      S_FINISHED: launch = go;
      S_ERROR:    launch = go;
      S_DELAY: begin
        if (cnt == DLY_LAST) begin
          cnt_n   = '0;
          state_n = S_PULSE;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      S_PULSE: begin
        // done arriving while the pulse is still high must not be lost
        if (done_cur) done_lat_n = 1'b1;
        if (cnt == PW_LAST) begin
          cnt_n   = '0;
          state_n = S_WAIT;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      S_WAIT: begin
        // done checked before timeout so a coincident done wins
        if (done_cur || done_lat) begin
          done_lat_n = 1'b0;
          cnt_n      = '0;
          if (stage == LAST_STAGE) begin
            state_n = S_FINISHED;
          end else begin
            stage_n = stage + SW'(1);
            state_n = S_PULSE;
          end
        end else if (TIMEOUT > 0) begin
          if (cnt == TO_LAST) begin
            state_n     = S_ERROR;
            err_stage_n = stage;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
      end
      default: state_n = S_IDLE;
    endcase

    if (launch) begin
      first_n     = 1'b0;
      stage_n     = '0;
      cnt_n       = '0;
      done_lat_n  = 1'b0;
      err_stage_n = '0;
      state_n     = (DELAY > 0) ? S_DELAY : S_PULSE;
    end
  end

  // all outputs decode registered state, so rst clears them asynchronously
  assign start     = (state == S_PULSE) ? (N_STAGES'(1) << stage) : '0;
  assign busy      = (state == S_DELAY) || (state == S_PULSE) || (state == S_WAIT);
  assign all_done  = (state == S_FINISHED);
  assign error     = (state == S_ERROR);
  assign err_stage = err_stage_q;

endmodule
